// File: rtl/axis_exp_adc_seq.sv
// axis_exp_adc_seq: trigger sequencer for the SPI ADC with an outstanding-conversion limit and AXIS accept snooping.
// Defining ADC_SEQ_EXT_TRIG_EN takes trigger slots from rising edges of ext_trig, rate-limited by the period.
module axis_exp_adc_seq #(
    parameter int CNT_WIDTH       = 32,
    parameter int MIN_PERIOD      = 24,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic                 start,
    input  logic                 abort,
`ifdef ADC_SEQ_EXT_TRIG_EN
    input  logic                 ext_trig,
`endif
    output logic                 adc_trigger,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] skipped,
    output logic [CNT_WIDTH-1:0] sample_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [CNT_WIDTH-1:0] MIN_P   = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [1:0]           MAX_OUT = 2'(MAX_OUTSTANDING);

    logic [1:0]           state_q, state_d, out_q, out_d, out_nx;
    logic [CNT_WIDTH-1:0] period_q, period_d, count_q, count_d, issued_q, issued_d;
    logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d, sample_q, sample_d, skipped_q, skipped_d;
    logic                 overrun_q, overrun_d, trig_q, trig_d, done_q, done_d;
    logic                 dec, slot, slot_ok;

`ifdef ADC_SEQ_EXT_TRIG_EN
    logic [2:0] sync_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], ext_trig};
    end
    // pcnt_q counts down from the last slot, so a nonzero value marks an edge that came too soon
    assign slot    = sync_q[1] & ~sync_q[2];
    assign slot_ok = pcnt_q == '0;
`else
    assign slot    = pcnt_q == '0;
    assign slot_ok = 1'b1;
`endif

    // Accepts with nothing outstanding are stray words and leave the counters alone
    assign dec    = mon_tvalid && mon_tready && out_q != 2'd0;
    assign out_nx = out_q - {1'b0, dec};

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        count_d   = count_q;
        issued_d  = issued_q;
        pcnt_d    = pcnt_q;
        out_d     = out_nx;
        sample_d  = sample_q + CNT_WIDTH'(dec);
        skipped_d = skipped_q;
        overrun_d = overrun_q;
        trig_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: if (start && !abort && cfg_count != '0) begin
                state_d   = S_RUN;
                period_d  = cfg_period < MIN_P ? MIN_P : cfg_period;
                count_d   = cfg_count;
                issued_d  = '0;
                pcnt_d    = '0;
                out_d     = '0;
                sample_d  = '0;
                skipped_d = '0;
                overrun_d = 1'b0;
            end
            S_RUN: if (abort) begin
                state_d = S_IDLE;
            end else begin
                pcnt_d = pcnt_q != '0 ? pcnt_q - ONE : '0;
                if (slot) begin
                    pcnt_d   = period_q - ONE;
                    issued_d = issued_q + ONE;
                    if (slot_ok && out_nx < MAX_OUT) begin
                        trig_d = 1'b1;
                        out_d  = out_nx + 2'd1;
                    end else begin
                        skipped_d = skipped_q + ONE;
                        overrun_d = 1'b1;
                    end
                    if (issued_d == count_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (abort) begin
                state_d = S_IDLE;
            end else if (out_q == 2'd0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            period_q  <= '0;
            count_q   <= '0;
            issued_q  <= '0;
            pcnt_q    <= '0;
            out_q     <= '0;
            sample_q  <= '0;
            skipped_q <= '0;
            overrun_q <= 1'b0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            count_q   <= count_d;
            issued_q  <= issued_d;
            pcnt_q    <= pcnt_d;
            out_q     <= out_d;
            sample_q  <= sample_d;
            skipped_q <= skipped_d;
            overrun_q <= overrun_d;
            trig_q    <= trig_d;
            done_q    <= done_d;
        end
    end

    assign adc_trigger = trig_q;
    assign busy        = state_q != S_IDLE;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign skipped     = skipped_q;
    assign sample_cnt  = sample_q;
endmodule

// File: tb/tb_axis_exp_adc_seq.sv
// tb_axis_exp_adc_seq: directed bench for the acquisition sequencer with a fixed-latency ADC responder.
module tb_axis_exp_adc_seq;
    localparam int W   = 32;
    localparam int LAT = 5;

    logic         aclk = 1'b0, aresetn = 1'b0;
    logic [W-1:0] cfg_period = '0, cfg_count = '0;
    logic         start = 1'b0, abort = 1'b0, mon_tready = 1'b0;
    logic         adc_tv = 1'b0, stray_tv = 1'b0, model_clr = 1'b0;
    logic         mon_tvalid;
    logic         adc_trigger, busy, done, overrun;
    logic [W-1:0] skipped, sample_cnt;

    int checks = 0, fails = 0;
    int cyc = 0, pend = 0, dly = 0, trig_n = 0, done_cnt = 0, done_at = 0;
    int trig_t[64];
    int n, b, d0;

    assign mon_tvalid = adc_tv | stray_tv;

    axis_exp_adc_seq dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_period(cfg_period), .cfg_count(cfg_count),
        .start(start), .abort(abort), .adc_trigger(adc_trigger),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .busy(busy), .done(done),
        .overrun(overrun), .skipped(skipped), .sample_cnt(sample_cnt)
    );

    always #5 aclk = ~aclk;

    // ADC responder: each trigger yields one word LAT cycles later, held until accepted
    always @(posedge aclk) begin
        cyc++;
        #1;
        if (model_clr) begin
            pend = 0; dly = 0; adc_tv = 1'b0;
        end else begin
            if (adc_tv && mon_tready) begin
                adc_tv = 1'b0; pend--; dly = 0;
            end
            if (adc_trigger) begin
                if (trig_n < 64) trig_t[trig_n] = cyc;
                trig_n++; pend++;
            end
            if (pend > 0 && !adc_tv) begin
                dly++;
                if (dly >= LAT) begin adc_tv = 1'b1; dly = 0; end
            end
        end
        if (done) begin done_cnt++; done_at = cyc; end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [W-1:0] p, input logic [W-1:0] c, output int edge_n);
        @(negedge aclk);
        cfg_period = p; cfg_count = c; start = 1'b1;
        @(posedge aclk);
        #1;
        edge_n = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int d;
        d = done_cnt;
        for (int i = 0; i < maxc && done_cnt == d; i++) @(negedge aclk);
        chk(tag, done_cnt - d, 1);
        @(negedge aclk);
        chk({tag, "_pulse_end"}, done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge aclk);
        chk("rst_trigger", adc_trigger, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_skipped", skipped, 0);
        chk("rst_sample", sample_cnt, 0);
        aresetn = 1'b1;

        // basic run
        mon_tready = 1'b1;
        b = trig_n;
        do_start(30, 4, n);
        chk("basic_busy_n1", busy, 1'b1);
        wait_done("basic_done", 200);
        chk("basic_trig_n", trig_n - b, 4);
        for (int k = 0; k < 4; k++) chk("basic_trig_t", trig_t[b+k] - n, 1 + 30*k);
        chk("basic_done_at", done_at - n, 97);
        chk("basic_sample", sample_cnt, 4);
        chk("basic_overrun", overrun, 1'b0);
        chk("basic_skipped", skipped, 0);
        chk("basic_busy_end", busy, 1'b0);

        // period clamp
        b = trig_n;
        do_start(5, 3, n);
        wait_done("clamp_done", 200);
        chk("clamp_trig_n", trig_n - b, 3);
        chk("clamp_first", trig_t[b] - n, 1);
        for (int k = 0; k < 2; k++) chk("clamp_space", trig_t[b+k+1] - trig_t[b+k], 24);

        // backpressure
        mon_tready = 1'b0;
        b = trig_n;
        d0 = done_cnt;
        do_start(24, 5, n);
        repeat (105) @(negedge aclk);
        chk("bp_trig_n", trig_n - b, 2);
        chk("bp_skipped", skipped, 3);
        chk("bp_overrun", overrun, 1'b1);
        chk("bp_busy_drain", busy, 1'b1);
        chk("bp_no_done", done_cnt - d0, 0);
        mon_tready = 1'b1;
        wait_done("bp_done", 50);
        chk("bp_sample", sample_cnt, 2);
        chk("bp_overrun_sticky", overrun, 1'b1);

        // slot coinciding with an accept at the outstanding limit
        mon_tready = 1'b0;
        b = trig_n;
        do_start(24, 3, n);
        repeat (48) @(posedge aclk);
        @(negedge aclk);
        mon_tready = 1'b1;
        @(negedge aclk);
        mon_tready = 1'b0;
        chk("sim_trigger", adc_trigger, 1'b1);
        chk("sim_skipped", skipped, 0);
        chk("sim_overrun", overrun, 1'b0);
        mon_tready = 1'b1;
        wait_done("sim_done", 60);
        chk("sim_trig_n", trig_n - b, 3);
        chk("sim_sample", sample_cnt, 3);

        // abort in the third period
        b = trig_n;
        d0 = done_cnt;
        do_start(30, 10, n);
        repeat (74) @(posedge aclk);
        @(negedge aclk);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_trigger", adc_trigger, 1'b0);
        chk("abort_sample", sample_cnt, 3);
        repeat (100) @(negedge aclk);
        chk("abort_trig_n", trig_n - b, 3);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_sample_hold", sample_cnt, 3);
        do_start(30, 1, n);
        chk("restart_busy", busy, 1'b1);
        chk("restart_sample_clr", sample_cnt, 0);
        wait_done("restart_done", 50);
        chk("restart_sample", sample_cnt, 1);

        // zero count and abort-over-start priority
        b = trig_n;
        d0 = done_cnt;
        @(negedge aclk);
        cfg_count = 0; start = 1'b1;
        repeat (3) @(negedge aclk);
        start = 1'b0;
        chk("zero_busy", busy, 1'b0);
        chk("zero_trig", trig_n - b, 0);
        chk("zero_sample", sample_cnt, 1);
        cfg_count = 3; start = 1'b1; abort = 1'b1;
        @(negedge aclk);
        start = 1'b0; abort = 1'b0;
        chk("prio_busy", busy, 1'b0);
        @(negedge aclk);
        chk("prio_trig", trig_n - b, 0);
        chk("zero_no_done", done_cnt - d0, 0);

        // asynchronous reset in DRAIN
        mon_tready = 1'b0;
        do_start(24, 3, n);
        repeat (55) @(posedge aclk);
        @(negedge aclk);
        chk("mid_busy", busy, 1'b1);
        chk("mid_skipped", skipped, 1);
        chk("mid_overrun", overrun, 1'b1);
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_overrun", overrun, 1'b0);
        chk("arst_skipped", skipped, 0);
        chk("arst_trigger", adc_trigger, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_sample", sample_cnt, 0);
        model_clr = 1'b1;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        model_clr = 1'b0;
        stray_tv = 1'b1; mon_tready = 1'b1;
        @(negedge aclk);
        stray_tv = 1'b0; mon_tready = 1'b0;
        chk("stray_sample", sample_cnt, 0);
        chk("stray_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/axis_exp_adc_seq.md
# axis_exp_adc_seq

Acquisition sequencer for the `axis_exp_adc` SPI ADC front end. It issues one-cycle `trigger` pulses at a programmable period for a programmable number of conversions. It also snoops the ADC's AXI-Stream handshake to count delivered samples and to flag overruns. It sits between the PS-side control registers and the ADC block, in the same `aclk` domain.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of the period and sample-count fields and counters.
- `MIN_PERIOD`, 24: minimum trigger spacing in `aclk` cycles. Covers `DATA_WIDTH/NUM_SDI` SCK cycles plus CSN overhead.
- `MAX_OUTSTANDING`, 2: maximum issued-but-unaccepted conversions, 1..3.

Ports:
- `aclk`  in  1  sole clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `cfg_period`  in  CNT_WIDTH  trigger period in cycles; latched on start.
- `cfg_count`  in  CNT_WIDTH  conversions per run; latched on start.
- `start`  in  1  level, sampled in IDLE.
- `abort`  in  1  synchronous abort, any state.
- `adc_trigger`  out  1  one-cycle pulse to `axis_exp_adc.trigger`.
- `mon_tvalid`  in  1  copy of the ADC `m_axis_tvalid`.
- `mon_tready`  in  1  copy of the ADC `m_axis_tready`.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `overrun`  out  1  sticky; cleared on the next accepted start.
- `skipped`  out  CNT_WIDTH  triggers suppressed by the outstanding limit in this run.
- `sample_cnt`  out  CNT_WIDTH  handshakes accepted in this run.

## Operation
- **Accept event:** `mon_tvalid && mon_tready` in a cycle.
- **States:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** `start=1` and `cfg_count != 0`.
  - Latch `period_q = max(cfg_period, MIN_PERIOD)` and `count_q = cfg_count`.
  - Clear `issued`, `sample_cnt`, `skipped`, `overrun` and `outstanding`.
  - Load the period counter with 0 so that the first trigger slot is immediate.
- **`start` with `cfg_count == 0`:** ignored; the block stays in IDLE and no `done` is produced.
- **RUN, trigger slot:** occurs when the period counter reaches 0. The counter is then reloaded with `period_q-1`.
  - If `outstanding_next < MAX_OUTSTANDING`, pulse `adc_trigger`, increment `issued` and increment `outstanding`.
  - Otherwise suppress the pulse, increment `skipped` and `issued`, and set `overrun`.
  - `outstanding_next` is `outstanding` minus any accept in the same cycle.
- **RUN → DRAIN:** when `issued == count_q` after a slot.
- **DRAIN → IDLE:** when `outstanding == 0`. `done` pulses in the same cycle as the transition.
- **Accept event, any state:** increments `sample_cnt` and decrements `outstanding`, saturating at 0.
  - An accept while `outstanding == 0` does not change `sample_cnt`. It is a stray word.
- **Trigger slot and accept in the same cycle:** `outstanding` is unchanged.
- **`abort` in RUN or DRAIN:**
  - Next state is IDLE.
  - `adc_trigger` and `busy` drop in the next cycle; `done` is not pulsed.
  - Counters hold their values for readback.
- **Abort priority:** `abort` has priority over `start` in the same cycle.
- **Arithmetic:** all counters are unsigned CNT_WIDTH and wrap modulo 2^CNT_WIDTH. `outstanding` is 2 bits.

## Timing
- **Reset values:** all outputs 0, state IDLE, `outstanding` 0.
- **Start latency:** `start` is seen high at edge N. Then `busy` is 1 and the first `adc_trigger` is high in cycle N+1.
- **Trigger spacing:** subsequent slots occur at N+1+k·`period_q`.
- **Trigger pulse width:** exactly 1 cycle.
- **Output registering:** outputs are registered; no combinational path from inputs to outputs.
- **`done` latency:** `done` is high one cycle after the cycle in which the final accept brings `outstanding` to 0. This holds when the final accept occurs in DRAIN.
- **Reset mid-run:** asserting `aresetn=0` mid-run returns all state to reset values immediately and asynchronously. Deassertion is synchronised by the reset bridge upstream.

## Configuration
- **`ADC_SEQ_EXT_TRIG_EN` defined:**
  - Adds port `ext_trig` (in, 1).
  - `ext_trig` passes through a 2-FF synchroniser and rising-edge detect.
  - In RUN, trigger slots occur on detected edges instead of the period counter.
  - Slots are still rate-limited: an edge less than `period_q` cycles after the previous slot is counted in `skipped` and sets `overrun`.
- **`ADC_SEQ_EXT_TRIG_EN` undefined:** no `ext_trig` port; slots come only from the internal period counter.

## Test plan
- **Basic run:** `cfg_period=30`, `cfg_count=4`, start; tready is held 1 and the ADC model responds.
  - Required: 4 triggers at +1, +31, +61, +91; `sample_cnt=4`; `done` pulse; `overrun=0`, `skipped=0`.
- **Clamp:** `cfg_period=5`.
  - Required: triggers spaced exactly 24 cycles.
- **Backpressure:** tready held 0, `cfg_count=5`, `cfg_period=24`.
  - Required: 2 triggers issued, then 3 skipped; `overrun=1`.
  - Raising tready lets DRAIN finish with `sample_cnt=2` and a `done` pulse.
- **Abort:** abort during the third period of a `cfg_count=10` run.
  - Required: no further triggers; `busy=0` next cycle; `done` never pulses.
  - `sample_cnt` holds its value; the next start clears it.
- **Zero count and simultaneity:**
  - `cfg_count=0` start: no state change.
  - A trigger slot coinciding with an accept at `outstanding=MAX_OUTSTANDING`: the trigger is issued, not skipped.
- **Reset mid-DRAIN:**
  - Required: all outputs 0 immediately.
  - A stray accept after reset: `sample_cnt` stays 0.
